bcd_countdown_2digit: RTL

- Two-digit BCD down-counter/timer. It is the counting-down counterpart of the lab's two-digit up-counter.
- Loads a preset 00..99 and decrements once every TICK_DIV clocks while running.
- Flags expiry at 00.
- Outputs dig1/dig0 use the same BCD digit format as the up-counter, so the existing display path consumes them unchanged.

---
 rtl/bcd_countdown_2digit_pkg.sv | 18 +
 rtl/bcd_countdown_2digit_if.sv | 25 ++
 rtl/bcd_countdown_2digit_digit_dec.sv | 24 ++
 rtl/bcd_countdown_2digit.sv | 100 ++++++++++
 4 files changed

// File: rtl/bcd_countdown_2digit_pkg.sv
// rtl/bcd_countdown_2digit_pkg.sv - shared types, constants and helpers for the BCD down-counter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_2digit_if.sv
// rtl/bcd_countdown_2digit_if.sv - command and status bundle of the BCD down-counter
interface bcd_countdown_2digit_if;

    logic       load;
    logic [3:0] load_dig1;
    logic [3:0] load_dig0;
    logic       start;
    logic       pause;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, load_dig1, load_dig0, start, pause,
        input  dig1, dig0, running, expired, done
    );

    modport slave (
        input  load, load_dig1, load_dig0, start, pause,
        output dig1, dig0, running, expired, done
    );

endinterface

// File: rtl/bcd_countdown_2digit_digit_dec.sv
// rtl/bcd_countdown_2digit_digit_dec.sv - single BCD digit decrement with borrow chain
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_2digit.sv
// rtl/bcd_countdown_2digit.sv - two-digit BCD countdown timer with prescaler, pause and expiry
module bcd_countdown_2digit
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    bcd_countdown_2digit_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [3:0]    dig1_q;
    logic [3:0]    dig0_q;
    logic          done_q;

    logic [3:0] dig0_nx;
    logic [3:0] dig1_nx;
    logic       ones_borrow;
    logic       tens_borrow;
    logic       is_zero;
    logic       dec_hits_zero;

    // Ones digit always borrows on a tick; its borrow feeds the tens digit.
    bcd_digit_dec u_ones (
        .digit      (dig0_q),
        .borrow_in  (1'b1),
        .next_digit (dig0_nx),
        .borrow_out (ones_borrow)
    );

    bcd_digit_dec u_tens (
        .digit      (dig1_q),
        .borrow_in  (ones_borrow),
        .next_digit (dig1_nx),
        .borrow_out (tens_borrow)
    );

    assign is_zero       = (dig1_q == BCD_ZERO) && (dig0_q == BCD_ZERO);
    assign dec_hits_zero = (dig1_nx == BCD_ZERO) && (dig0_nx == BCD_ZERO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            dig1_q    <= BCD_ZERO;
            dig0_q    <= BCD_ZERO;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                dig1_q    <= bcd_clamp(bus.load_dig1);
                dig0_q    <= bcd_clamp(bus.load_dig0);
                state     <= IDLE;
                prescaler <= '0;
            end else if (bus.pause && state == RUN) begin
                state <= PAUSED;
            end else if (bus.start && (state == IDLE || state == EXPIRED)) begin
                if (is_zero) begin
                    state  <= EXPIRED;
                    done_q <= 1'b1;
                end else begin
                    state     <= RUN;
                    prescaler <= '0;
                end
            end else if (bus.start && state == PAUSED) begin
                state <= RUN;
            end else if (state == RUN) begin
                if (prescaler != PRE_LAST) begin
                    prescaler <= prescaler + 1'b1;
                end else begin
                    prescaler <= '0;
                    // A tens borrow would mean underflow below 00; hold and expire instead.
                    if (tens_borrow) begin
                        state  <= EXPIRED;
                        done_q <= 1'b1;
                    end else begin
                        dig1_q <= dig1_nx;
                        dig0_q <= dig0_nx;
                        if (dec_hits_zero) begin
                            state  <= EXPIRED;
                            done_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.dig1    = dig1_q;
    assign bus.dig0    = dig0_q;
    assign bus.running = (state == RUN);
    assign bus.expired = (state == EXPIRED);
    assign bus.done    = done_q;

endmodule
